sram16_byte_lane_model: RTL and testbench

- Synthesizable, clocked model of a 16-bit-wide, byte-lane-addressable asynchronous SRAM of the IS61LV6416L class.
- Used as the external SRAM behind the Minimig chipset memory controller in the CPU/chipset bench.
- Keeps the device's active-low control pin set (CE_, OE_, WE_, LB_, UB_).
- The bidirectional IO bus is split into input, output and per-lane output-enable so the block is usable in pure RTL simulation and on FPGA.

---
 rtl/sram16_byte_lane_model.sv | 98 +++++++++
 tb/tb_sram16_byte_lane_model.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram16_byte_lane_model.sv
// Clocked model of a 16-bit asynchronous SRAM with byte-lane selects.
// The bidirectional IO bus is split into IO_i, IO_o and a per-lane IO_oe.
// Each byte lane is kept in its own 8-bit array, with a registered read port.
module sram16_byte_lane_model #(
  parameter int memdepth = 262144,
  parameter int addbits  = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [addbits-1:0] A,
  input  logic [15:0]        IO_i,
  output logic [15:0]        IO_o,
  output logic [1:0]         IO_oe,
  input  logic               CE_,
  input  logic               OE_,
  input  logic               WE_,
  input  logic               LB_,
  input  logic               UB_,
  output logic               oor
);

  // The index is only as wide as the array needs. Out-of-range addresses
  // are caught by in_range before the truncated index is ever used.
  localparam int IDX_W = (memdepth > 1) ? $clog2(memdepth) : 1;
  localparam logic [addbits:0] DEPTH_L = memdepth[addbits:0];

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_en;
  logic             rd_en;
  logic             acc_en;
  logic [1:0]       lane_sel_n;

  logic [1:0]       io_oe_q, io_oe_d;
  logic             oor_q, oor_d;

  assign in_range   = ({1'b0, A} < DEPTH_L);
  assign idx        = A[IDX_W-1:0];
  assign lane_sel_n = {UB_, LB_};

  // WE_ has priority over OE_. A write presented during reset is dropped.
  assign wr_en  = !rst && !CE_ && !WE_ && in_range;
  assign rd_en  = !CE_ && WE_ && !OE_;
  assign acc_en = !CE_ && (!WE_ || !OE_);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [memdepth];
      logic [7:0] rd_q;

      // Lane write: only when this lane's select is low.
      always_ff @(posedge clk) begin
        if (wr_en && !lane_sel_n[gi]) begin
          mem[idx] <= IO_i[gi*8 +: 8];
        end
      end

      // Registered read. It returns zero for out-of-range reads and holds
      // its value on cycles that are not reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= 8'h00;
        end else if (rd_en) begin
          rd_q <= in_range ? mem[idx] : 8'h00;
        end
      end

      assign IO_o[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // Next state for the lane enables and the out-of-range flag.
  always_comb begin
    io_oe_d = 2'b00;
    oor_d   = oor_q;
    if (rd_en) begin
      io_oe_d = ~lane_sel_n;
    end
    if (acc_en) begin
      oor_d = !in_range;
    end
  end

  // Control state registers. Reset cancels any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_oe_q <= 2'b00;
      oor_q   <= 1'b0;
    end else begin
      io_oe_q <= io_oe_d;
      oor_q   <= oor_d;
    end
  end

  assign IO_oe = io_oe_q;
  assign oor   = oor_q;

endmodule

// File: tb/tb_sram16_byte_lane_model.sv
// Bench for sram16_byte_lane_model. It drives a full-depth instance and a
// 1024-word instance with the same stimulus, and checks both against a
// byte-addressed reference memory.
module tb_sram16_byte_lane_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] A;
  logic [15:0] IO_i;
  logic        CE_, OE_, WE_, LB_, UB_;

  logic [15:0] io_o_f, io_o_s;
  logic [1:0]  oe_f, oe_s;
  logic        oor_f, oor_s;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference state. Index 0 is the full instance, 1 is the small one.
  int          depth [2] = '{262144, 1024};
  logic [15:0] exp_o    [2];
  logic [15:0] exp_mask [2];
  logic [1:0]  exp_oe   [2];
  logic        exp_oor  [2];
  logic [7:0]  mdl [int];  // key: inst*2^20 + addr*2 + lane

  always #5 clk = ~clk;

  sram16_byte_lane_model #(.memdepth(262144), .addbits(18)) dut_full (
    .clk(clk), .rst(rst), .A(A), .IO_i(IO_i), .IO_o(io_o_f), .IO_oe(oe_f),
    .CE_(CE_), .OE_(OE_), .WE_(WE_), .LB_(LB_), .UB_(UB_), .oor(oor_f)
  );

  sram16_byte_lane_model #(.memdepth(1024), .addbits(18)) dut_small (
    .clk(clk), .rst(rst), .A(A), .IO_i(IO_i), .IO_o(io_o_s), .IO_oe(oe_s),
    .CE_(CE_), .OE_(OE_), .WE_(WE_), .LB_(LB_), .UB_(UB_), .oor(oor_s)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one transaction for one clock edge, update the reference, and
  // check both instances #1 after the edge.
  task automatic do_op(input logic r, input logic [17:0] a,
                       input logic [15:0] d, input logic ce, input logic oe,
                       input logic we, input logic lb, input logic ub);
    logic [15:0] obs_o;
    logic [1:0]  obs_oe;
    logic        obs_oor;
    logic        lane_n [2];
    rst = r; A = a; IO_i = d; CE_ = ce; OE_ = oe; WE_ = we; LB_ = lb; UB_ = ub;
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%0b A=%05h D=%04h CE_=%0b OE_=%0b WE_=%0b LB_=%0b UB_=%0b",
             n_txn, r, a, d, ce, oe, we, lb, ub);
    lane_n[0] = lb;
    lane_n[1] = ub;
    for (int dd = 0; dd < 2; dd++) begin
      bit in_rng;
      in_rng = (int'(a) < depth[dd]);
      if (r) begin
        exp_oe[dd] = 2'b00; exp_o[dd] = 16'h0000;
        exp_mask[dd] = 16'hFFFF; exp_oor[dd] = 1'b0;
      end else if (!ce && !we) begin
        if (in_rng) begin
          for (int ln = 0; ln < 2; ln++)
            if (!lane_n[ln]) mdl[dd*(1<<20) + int'(a)*2 + ln] = d[ln*8 +: 8];
        end
        exp_oe[dd] = 2'b00;
        exp_mask[dd] = 16'h0000;
        exp_oor[dd] = !in_rng;
      end else if (!ce && !oe) begin
        exp_oe[dd] = {~ub, ~lb};
        exp_oor[dd] = !in_rng;
        exp_o[dd] = 16'h0000;
        exp_mask[dd] = 16'hFFFF;
        if (in_rng) begin
          exp_mask[dd] = 16'h0000;
          for (int ln = 0; ln < 2; ln++) begin
            int k;
            k = dd*(1<<20) + int'(a)*2 + ln;
            if (mdl.exists(k)) begin
              exp_o[dd][ln*8 +: 8] = mdl[k];
              exp_mask[dd][ln*8 +: 8] = 8'hFF;
            end
          end
        end
      end else begin
        exp_oe[dd] = 2'b00;
      end
      obs_o   = (dd == 0) ? io_o_f : io_o_s;
      obs_oe  = (dd == 0) ? oe_f : oe_s;
      obs_oor = (dd == 0) ? oor_f : oor_s;
      check_val(dd == 0 ? "full_io_oe" : "small_io_oe", 32'(obs_oe), 32'(exp_oe[dd]));
      check_val(dd == 0 ? "full_oor" : "small_oor", 32'(obs_oor), 32'(exp_oor[dd]));
      if (exp_mask[dd] != 16'h0000)
        check_val(dd == 0 ? "full_io_o" : "small_io_o",
                  32'(obs_o & exp_mask[dd]), 32'(exp_o[dd] & exp_mask[dd]));
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; IO_i = '0;
    CE_ = 1'b1; OE_ = 1'b1; WE_ = 1'b1; LB_ = 1'b1; UB_ = 1'b1;

    // Reset held two cycles with a read presented.
    do_op(1, 18'h0, 16'h0, 0, 0, 1, 0, 0);
    check_val("rst_oe", 32'(oe_f), 32'h0);
    check_val("rst_io_o", 32'(io_o_f), 32'h0);
    do_op(1, 18'h0, 16'h0, 0, 0, 1, 0, 0);
    do_op(0, 18'h0, 16'h0, 0, 0, 1, 0, 0);
    check_val("rel_oe", 32'(oe_f), 32'h3);

    // Full-word write, then read back.
    do_op(0, 18'h10, 16'hA55A, 0, 1, 0, 0, 0);
    do_op(0, 18'h10, 16'h0000, 0, 0, 1, 0, 0);
    check_val("word_rd", 32'(io_o_f), 32'hA55A);
    check_val("word_oe", 32'(oe_f), 32'h3);

    // Byte lanes.
    do_op(0, 18'h5, 16'h1234, 0, 1, 0, 0, 0);
    do_op(0, 18'h5, 16'hFFEE, 0, 1, 0, 0, 1);
    do_op(0, 18'h5, 16'h0000, 0, 0, 1, 0, 0);
    check_val("lane_rd", 32'(io_o_f), 32'h12EE);
    do_op(0, 18'h5, 16'h0000, 0, 0, 1, 1, 0);
    check_val("lane_oe", 32'(oe_f), 32'h2);

    // Control priority.
    do_op(0, 18'h5, 16'hDEAD, 1, 1, 0, 0, 0);
    do_op(0, 18'h5, 16'h0000, 0, 0, 1, 0, 0);
    check_val("ce_block", 32'(io_o_f), 32'h12EE);
    do_op(0, 18'h5, 16'h1111, 0, 0, 0, 1, 1);
    check_val("we_prio_oe", 32'(oe_f), 32'h0);

    // Back-to-back write then read at the top address.
    do_op(0, 18'h3FFFF, 16'hBEEF, 0, 1, 0, 0, 0);
    do_op(0, 18'h3FFFF, 16'h0000, 0, 0, 1, 0, 0);
    check_val("b2b_rd", 32'(io_o_f), 32'hBEEF);
    check_val("b2b_oor_full", 32'(oor_f), 32'h0);

    // Out-of-range accesses on the 1024-word instance.
    do_op(0, 18'd1024, 16'h5555, 0, 1, 0, 0, 0);
    check_val("oor_wr", 32'(oor_s), 32'h1);
    do_op(0, 18'd1024, 16'h0000, 0, 0, 1, 0, 0);
    check_val("oor_rd_data", 32'(io_o_s), 32'h0);
    check_val("oor_rd_flag", 32'(oor_s), 32'h1);
    do_op(0, 18'd0, 16'h0000, 1, 1, 1, 1, 1);
    check_val("oor_idle_hold", 32'(oor_s), 32'h1);
    do_op(0, 18'd0, 16'h0000, 0, 0, 1, 0, 0);
    check_val("oor_clear", 32'(oor_s), 32'h0);

    // Randomized traffic over address pools near both depth boundaries.
    for (int t = 0; t < 600; t++) begin
      logic [17:0] a;
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 0)      a = 18'($urandom_range(0, 15));
      else if (sel == 1) a = 18'($urandom_range(1016, 1031));
      else               a = 18'h3FFFF - 18'($urandom_range(0, 15));
      do_op(($urandom_range(0, 49) == 0), a, 16'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
